// File: rtl/fetch_stage.sv
// LC-3 instruction fetch stage: owns the PC, issues single-outstanding imem reads,
// buffers one word across downstream stalls and squashes reads orphaned by a redirect.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        if_id_load,
  output logic [15:0] if_plus2_out,
  output logic [15:0] if_instr_out
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;

  logic [15:0] pc_plus2;
  logic        read_c;
  logic        load_c;
  logic [15:0] instr_c;

  // Wraps modulo 2^16, so FFFE advances to 0000.
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    redirect_pc_d = redirect_pc_q;
    read_c        = 1'b0;
    load_c        = 1'b0;
    instr_c       = 16'h0000;

    case (state_q)
      FETCH: begin
        read_c = 1'b1;
        if (redirect) begin
          if (imem_resp) begin
            pc_d = redirect_target;
          end else begin
            // The read in flight must finish at its original address before we move on.
            redirect_pc_d = redirect_target;
            state_d       = SQUASH;
          end
        end else if (imem_resp) begin
          if (!stall_in) begin
            load_c  = 1'b1;
            instr_c = imem_rdata;
            pc_d    = pc_plus2;
          end else begin
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = FETCH;
        end else if (!stall_in) begin
          load_c  = 1'b1;
          instr_c = hold_instr_q;
          pc_d    = pc_plus2;
          state_d = FETCH;
        end
      end

      SQUASH: begin
        read_c = 1'b1;
        if (redirect) begin
          redirect_pc_d = redirect_target;
        end
        if (imem_resp) begin
          // The youngest redirect wins, including one arriving with the stale response.
          pc_d    = redirect ? redirect_target : redirect_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_instr_q  <= 16'h0000;
      redirect_pc_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Reset silences every output immediately, independent of the clock.
  assign imem_read    = !reset && read_c;
  assign imem_address = reset ? 16'h0000 : pc_q;
  assign if_id_load   = !reset && load_c;
  assign if_instr_out = if_id_load ? instr_c : 16'h0000;
  assign if_plus2_out = if_id_load ? pc_plus2 : 16'h0000;

  a_no_load_on_redirect: assert property (
    @(posedge clk) disable iff (reset) !(if_id_load && redirect)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model drives
// responses and a queue of expected (PC+2, word) pairs is checked on each load.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        if_id_load;
  logic [15:0] if_plus2_out;
  logic [15:0] if_instr_out;

  typedef struct packed {
    logic [15:0] plus2;
    logic [15:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          loads = 0;
  int          lat = 1;
  int          age = 0;
  logic [15:0] req_addr = 16'h0000;

  fetch_stage #(.RESET_PC(16'h3000)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .if_id_load      (if_id_load),
    .if_plus2_out    (if_plus2_out),
    .if_instr_out    (if_instr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_load(input logic [15:0] a);
    exp_t e;
    e.plus2 = a + 16'd2;
    e.instr = mem_word(a);
    exp_q.push_back(e);
  endtask

  // One pipeline cycle: inputs change on the falling edge, outputs are checked 1 unit later.
  task automatic tick(input logic st, input logic rd, input logic [15:0] tg);
    exp_t e;
    @(negedge clk);
    stall_in        = st;
    redirect        = rd;
    redirect_target = tg;
    imem_resp       = 1'b0;
    imem_rdata      = 16'hDEAD;
    if (imem_read) begin
      if (age == 0) req_addr = imem_address;
      else check("addr_stable", imem_address, req_addr);
      age++;
      if (age >= lat) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(req_addr);
        age        = 0;
      end
    end else begin
      age = 0;
    end
    #1;
    if (if_id_load) begin
      loads++;
      if (exp_q.size() == 0) begin
        check("unexpected_load", {31'd0, if_id_load}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("load_plus2", if_plus2_out, e.plus2);
        check("load_instr", if_instr_out, e.instr);
      end
    end else begin
      check("idle_plus2", if_plus2_out, 32'd0);
      check("idle_instr", if_instr_out, 32'd0);
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    stall_in        = 1'b0;
    redirect        = 1'b0;
    redirect_target = 16'h0000;
    imem_resp       = 1'b0;
    imem_rdata      = 16'h0000;
    #1;
    check("rst_read",  {31'd0, imem_read}, 32'd0);
    check("rst_addr",  imem_address, 32'd0);
    check("rst_load",  {31'd0, if_id_load}, 32'd0);
    check("rst_plus2", if_plus2_out, 32'd0);
    check("rst_instr", if_instr_out, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    age   = 0;
    loads = 0;
    exp_q.delete();
    #1;
    check("first_read", {31'd0, imem_read}, 32'd1);
    check("first_addr", imem_address, 32'h3000);
  endtask

  initial begin
    // Latency 1: back-to-back loads with no bubble
    lat = 1;
    do_reset();
    expect_load(16'h3000);
    expect_load(16'h3002);
    expect_load(16'h3004);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0000);
    check("s1_loads", loads, 32'd3);
    check("s1_drained", exp_q.size(), 32'd0);

    // Latency 3 with a stall covering the 3002 response
    lat = 3;
    do_reset();
    expect_load(16'h3000);
    expect_load(16'h3002);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0000);
    check("s2_first_load", loads, 32'd1);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000);
    check("s2_no_load_stalled", loads, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 16'h0000);
      check("s2_hold_no_read", {31'd0, imem_read}, 32'd0);
    end
    tick(1'b0, 1'b0, 16'h0000);
    check("s2_release_load", loads, 32'd2);
    tick(1'b0, 1'b0, 16'h0000);
    check("s2_next_read", {31'd0, imem_read}, 32'd1);
    check("s2_next_addr", imem_address, 32'h3004);
    check("s2_drained", exp_q.size(), 32'd0);

    // Latency 4, redirect while the 3000 read is outstanding
    lat = 4;
    do_reset();
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b1, 16'h4000);
    check("s3_addr_held", imem_address, 32'h3000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s3_squash_read", {31'd0, imem_read}, 32'd1);
    tick(1'b0, 1'b0, 16'h0000);
    check("s3_dropped", loads, 32'd0);
    expect_load(16'h4000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s3_new_addr", imem_address, 32'h4000);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0000);
    check("s3_loads", loads, 32'd1);
    check("s3_drained", exp_q.size(), 32'd0);

    // Second redirect while squashing overrides the first
    lat = 4;
    do_reset();
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b1, 16'h4000);
    tick(1'b0, 1'b1, 16'h5000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s4_dropped", loads, 32'd0);
    expect_load(16'h5000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s4_new_addr", imem_address, 32'h5000);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0000);
    check("s4_loads", loads, 32'd1);

    // Redirect with response and stall in the same cycle: no load, no hold
    lat = 2;
    do_reset();
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 16'h6000);
    check("s5_no_load", loads, 32'd0);
    expect_load(16'h6000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s5_read", {31'd0, imem_read}, 32'd1);
    check("s5_addr", imem_address, 32'h6000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s5_loads", loads, 32'd1);

    // Redirect arriving with the stale response while squashing
    lat = 2;
    do_reset();
    tick(1'b0, 1'b1, 16'h4000);
    tick(1'b0, 1'b1, 16'h7000);
    check("s6_dropped", loads, 32'd0);
    expect_load(16'h7000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s6_addr", imem_address, 32'h7000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s6_loads", loads, 32'd1);

    // Redirect beats a stall while holding
    lat = 1;
    do_reset();
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b1, 1'b1, 16'h8000);
    check("s7_no_load", loads, 32'd0);
    expect_load(16'h8000);
    tick(1'b0, 1'b0, 16'h0000);
    check("s7_addr", req_addr, 32'h8000);
    check("s7_loads", loads, 32'd1);

    // PC wrap at FFFE, then reset in the middle of a read
    lat = 1;
    do_reset();
    tick(1'b0, 1'b1, 16'hFFFE);
    check("s8_dropped", loads, 32'd0);
    expect_load(16'hFFFE);
    tick(1'b0, 1'b0, 16'h0000);
    check("s8_wrap_addr", imem_address, 32'hFFFE);
    check("s8_loads", loads, 32'd1);
    lat = 3;
    tick(1'b0, 1'b0, 16'h0000);
    check("s8_next_read", {31'd0, imem_read}, 32'd1);
    check("s8_next_addr", imem_address, 32'h0000);
    do_reset();
    tick(1'b0, 1'b0, 16'h0000);
    check("s8_after_rst_addr", imem_address, 32'h3000);
    check("s8_after_rst_loads", loads, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined LC-3. Owns the PC and drives the instruction-memory request port, which has multi-cycle latency through the L1/L2 hierarchy.
- Delivers one instruction per accepted fetch to the IF/ID register: instruction word, PC+2 and a load strobe.
- Absorbs downstream stalls with a one-entry hold buffer.
- Handles branch/jump redirects, including a redirect that arrives while a memory read is still outstanding. The stale response is squashed.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall_in  input  1  downstream cannot accept an instruction this cycle
- redirect  input  1  control-flow redirect from a later stage; one-cycle pulse
- redirect_target  input  16  new PC, valid when redirect=1
- imem_read  output  1  instruction memory read request
- imem_address  output  16  instruction memory address
- imem_resp  input  1  read data valid this cycle; one-cycle pulse
- imem_rdata  input  16  instruction word, valid with imem_resp
- if_id_load  output  1  load strobe to the IF/ID register
- if_plus2_out  output  16  PC+2 of the delivered instruction
- if_instr_out  output  16  delivered instruction word

Behaviour:
- Reset is asynchronous. Setting: pc=RESET_PC, state=FETCH, hold buffer cleared, redirect_pc=0.
- While reset=1, all outputs are forced to 0.
- First request occurs in the first cycle after reset deasserts.
- Reset mid-read abandons the read. Any imem_resp in the cycle after reset releases is ignored unless the state is FETCH and a new read is in progress.
- Registers: pc[15:0], state, hold_instr[15:0], redirect_pc[15:0].
- Adder: PC+2 is modulo 2^16, so 16'hFFFE+2 = 16'h0000.
- Outputs are combinational from state and inputs. if_plus2_out and if_instr_out are 0 whenever if_id_load=0.

FETCH state:
- imem_read=1, imem_address=pc.
- redirect=1 and imem_resp=1: drop the data, pc<=redirect_target, stay FETCH, if_id_load=0.
- redirect=1 and imem_resp=0: redirect_pc<=redirect_target, go to SQUASH, pc unchanged. The address stays stable until the outstanding read completes.
- imem_resp=1 and stall_in=0: if_id_load=1, if_instr_out=imem_rdata, if_plus2_out=pc+2, pc<=pc+2, stay FETCH. This gives back-to-back fetch with no bubble.
- imem_resp=1 and stall_in=1: hold_instr<=imem_rdata, go to HOLD, if_id_load=0.
- imem_resp=0: no change. stall_in is ignored.

HOLD state:
- imem_read=0, imem_address=pc.
- redirect=1: drop the buffer, pc<=redirect_target, go to FETCH, if_id_load=0. Redirect has priority over stall.
- stall_in=0: if_id_load=1, if_instr_out=hold_instr, if_plus2_out=pc+2, pc<=pc+2, go to FETCH.
- stall_in=1: remain in HOLD.

SQUASH state:
- imem_read=1, imem_address=pc (the old address).
- redirect=1 (any imem_resp): redirect_pc<=redirect_target. The youngest redirect wins.
- imem_resp=1: data discarded, if_id_load=0. pc<=redirect_target if redirect=1 this cycle, else redirect_pc. Go to FETCH.

General rules:
- if_id_load is never 1 in the same cycle as redirect=1.
- At most one outstanding read at any time.
- imem_address never changes while imem_read=1 and no imem_resp has been received for that request.

Test Plan:
- Reset with RESET_PC=16'h3000, memory latency 1, no stall -> loads every cycle after the first response: if_plus2_out=3002, 3004, 3006; instructions match memory at 3000, 3002, 3004.
- Latency 3, stall_in=1 for 4 cycles starting at the cycle of the 16'h3002 response -> state HOLD, imem_read=0. After release, one load with if_plus2_out=3004 and the buffered word, then a read of 3004.
- Latency 4, redirect to 16'h4000 on the cycle after the request to 3000 -> address stays 3000 until resp. Response dropped with no load. Next read at 4000, first load if_plus2_out=4002.
- In SQUASH, second redirect to 16'h5000 one cycle before the resp -> next fetch at 5000, not 4000.
- Redirect to 16'h6000 in the same cycle as imem_resp, with stall_in=1 -> no load, no HOLD entered. Next address 6000.
- pc=16'hFFFE, resp without stall -> if_plus2_out=0000, next imem_address=0000. Assert reset during an outstanding read -> outputs 0 immediately. After release, read at RESET_PC.
